mrr_pathway_output_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one 32-bit AXI-stream output (loopback o_tdata path) among
//  NUM_PATHWAYS decode-pathway sources. A grant locks onto one pathway until that pathway's tlast beat

---
 rtl/mrr_pathway_output_arbiter_if.sv | 27 ++
 rtl/mrr_pathway_output_arbiter.sv | 86 ++++++++
 tb/tb_mrr_pathway_output_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mrr_pathway_output_arbiter_if.sv
// mrr_pathway_output_arbiter_if: per-pathway AXI-stream inputs, shared output and arbiter status
interface mrr_pathway_output_arbiter_if #(
  parameter int NUM_PATHWAYS = 2,
  parameter int PATHWAY_LOG2 = 1
);
  logic [32*NUM_PATHWAYS-1:0] in_tdata;
  logic [NUM_PATHWAYS-1:0]    in_tvalid;
  logic [NUM_PATHWAYS-1:0]    in_tlast;
  logic [NUM_PATHWAYS-1:0]    in_tkeep;
  logic [NUM_PATHWAYS-1:0]    in_tready;
  logic [31:0]                out_tdata;
  logic                       out_tvalid;
  logic                       out_tlast;
  logic                       out_tkeep;
  logic                       out_tready;
  logic [PATHWAY_LOG2-1:0]    grant_idx;
  logic                       busy;
  logic                       timeout_pulse;
  modport master (
    input  in_tdata, in_tvalid, in_tlast, in_tkeep, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast, out_tkeep, grant_idx, busy, timeout_pulse
  );
  modport slave (
    output in_tdata, in_tvalid, in_tlast, in_tkeep, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast, out_tkeep, grant_idx, busy, timeout_pulse
  );
endinterface

// File: rtl/mrr_pathway_output_arbiter.sv
// mrr_pathway_output_arbiter: packet-locked round-robin mux of pathway streams onto one output.
// Optional stall abort enabled by defining MRR_ARB_TIMEOUT_EN.
module mrr_pathway_output_arbiter #(
  parameter int NUM_PATHWAYS   = 2,
  parameter int PATHWAY_LOG2   = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input logic clk,
  input logic rst,
  mrr_pathway_output_arbiter_if.master bus
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic [PATHWAY_LOG2-1:0] grant_q, grant_d, win, idx;
  logic [31:0] own_data;
  logic own_valid, own_last, own_keep, accept, done, to, lock;
  // Descending scan so the nearest requester after grant_q is assigned last and wins
  always_comb begin
    win = grant_q;
    idx = '0;
    for (int i = NUM_PATHWAYS; i >= 1; i--) begin
      idx = PATHWAY_LOG2'((int'(grant_q) + i) % NUM_PATHWAYS);
      if (bus.in_tvalid[idx]) win = idx;
    end
  end
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_keep  = 1'b0;
    for (int p = 0; p < NUM_PATHWAYS; p++) begin
      if (grant_q == PATHWAY_LOG2'(p)) begin
        own_data  = bus.in_tdata[32*p +: 32];
        own_valid = bus.in_tvalid[p];
        own_last  = bus.in_tlast[p];
        own_keep  = bus.in_tkeep[p];
      end
    end
  end
  assign lock   = state_q == LOCK;
  assign accept = lock && own_valid && bus.out_tready;
  assign done   = accept && own_last;
`ifdef MRR_ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  // Only owner-side starvation counts; downstream backpressure never aborts a packet
  always_comb begin
    to    = lock && !own_valid && cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    cnt_d = (!lock || accept) ? '0 : (!own_valid ? cnt_q + 1'b1 : cnt_q);
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= PATHWAY_LOG2'(NUM_PATHWAYS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (!lock && |bus.in_tvalid) begin
      state_d = LOCK;
      grant_d = win;
    end else if (lock && (done || to)) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    bus.out_tdata     = lock ? own_data : '0;
    bus.out_tvalid    = lock && own_valid;
    bus.out_tlast     = lock && own_last;
    bus.out_tkeep     = lock && own_keep;
    bus.grant_idx     = grant_q;
    bus.busy          = lock;
    bus.timeout_pulse = to;
    bus.in_tready     = '0;
    for (int p = 0; p < NUM_PATHWAYS; p++)
      bus.in_tready[p] = lock && grant_q == PATHWAY_LOG2'(p) && bus.out_tready;
  end
endmodule

// File: tb/tb_mrr_pathway_output_arbiter.sv
// tb_mrr_pathway_output_arbiter: directed checks of grant rotation, locking, backpressure and reset.
module tb_mrr_pathway_output_arbiter;
`ifdef MRR_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int bp[2];
  int plen[2];
  logic [1:0] vmask;
  always #5 clk = ~clk;
  mrr_pathway_output_arbiter_if #(.NUM_PATHWAYS(2), .PATHWAY_LOG2(1)) bus ();
  mrr_pathway_output_arbiter #(
    .NUM_PATHWAYS(2), .PATHWAY_LOG2(1), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(13)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] expd(input int p, input int b);
    return {(p == 1) ? 16'hA5A5 : 16'hB0B0, 16'(b + 1)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      bus.in_tdata[32*p +: 32] = expd(p, bp[p]);
      bus.in_tlast[p] = bp[p] == plen[p] - 1;
      bus.in_tkeep[p] = vmask[p];
    end
    bus.in_tvalid = vmask;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input string tag, input int own, input int b, input int len);
    chk({tag, "_grant"}, 32'(bus.grant_idx), 32'(own));
    chk({tag, "_valid"}, 32'(bus.out_tvalid), 32'd1);
    chk({tag, "_data"}, bus.out_tdata, expd(own, b));
    chk({tag, "_last"}, 32'(bus.out_tlast), 32'(b == len - 1));
    chk({tag, "_ready"}, 32'(bus.in_tready), 32'(1 << own));
    tick();
    bp[own] = (b == len - 1) ? 0 : b + 1;
    drive();
  endtask
  initial begin
    bus.out_tready = 1'b1;
    vmask = 2'b00;
    bp = '{0, 0};
    plen = '{3, 3};
    drive();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant", 32'(bus.grant_idx), 32'd1);
    chk("rst_valid", 32'(bus.out_tvalid), 32'd0);
    chk("rst_data", bus.out_tdata, 32'd0);
    chk("rst_ready", 32'(bus.in_tready), 32'd0);
    chk("rst_to", 32'(bus.timeout_pulse), 32'd0);
    // Both pathways request continuously: grants 0,1,0,1 with a bubble before each packet
    vmask = 2'b11;
    drive();
    for (int k = 0; k < 4; k++) begin
      chk("t1_idle_busy", 32'(bus.busy), 32'd0);
      chk("t1_idle_valid", 32'(bus.out_tvalid), 32'd0);
      chk("t1_idle_ready", 32'(bus.in_tready), 32'd0);
      tick();
      drive();
      for (int b = 0; b < 3; b++) beat("t1", k % 2, b, 3);
    end
    vmask = 2'b10;
    drive();
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    drive();
    for (int b = 0; b < 3; b++) beat("t2", 1, b, 3);
    vmask = 2'b01;
    drive();
    tick();
    drive();
    beat("t3", 0, 0, 3);
    bus.out_tready = 1'b0;
    drive();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(bus.out_tvalid), 32'd1);
      chk("t3_hold_data", bus.out_tdata, expd(0, 1));
      chk("t3_hold_ready", 32'(bus.in_tready), 32'd0);
      tick();
    end
    bus.out_tready = 1'b1;
    drive();
    beat("t3", 0, 1, 3);
    beat("t3", 0, 2, 3);
    vmask = 2'b10;
    drive();
    chk("t4_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    drive();
    beat("t4", 1, 0, 3);
    vmask = 2'b01;
    drive();
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_grant", 32'(bus.grant_idx), 32'd1);
      chk("t4_stall_busy", 32'(bus.busy), 32'd1);
      chk("t4_stall_valid", 32'(bus.out_tvalid), 32'd0);
      chk("t4_stall_ready", 32'(bus.in_tready), 32'd2);
      chk("t4_stall_to", 32'(bus.timeout_pulse), 32'd0);
      tick();
    end
    vmask = 2'b11;
    plen[0] = 4;
    drive();
    beat("t4", 1, 1, 3);
    beat("t4", 1, 2, 3);
    chk("t5_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    drive();
    beat("t5", 0, 0, 4);
    chk("t5_beat2_data", bus.out_tdata, expd(0, 1));
    rst = 1'b1;
    tick();
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_valid", 32'(bus.out_tvalid), 32'd0);
    chk("t5_rst_grant", 32'(bus.grant_idx), 32'd1);
    chk("t5_rst_ready", 32'(bus.in_tready), 32'd0);
    rst = 1'b0;
    vmask = 2'b00;
    bp = '{0, 0};
    plen = '{3, 3};
    drive();
    tick();
`ifdef MRR_ARB_TIMEOUT_EN
    vmask = 2'b11;
    drive();
    tick();
    drive();
    beat("t6", 0, 0, 3);
    vmask = 2'b10;
    drive();
    for (int k = 1; k <= 16; k++) begin
      chk("t6_stall_busy", 32'(bus.busy), 32'd1);
      chk("t6_stall_to", 32'(bus.timeout_pulse), 32'(k == 16));
      tick();
    end
    chk("t6_idle_busy", 32'(bus.busy), 32'd0);
    chk("t6_idle_to", 32'(bus.timeout_pulse), 32'd0);
    tick();
    drive();
    chk("t6_regrant", 32'(bus.grant_idx), 32'd1);
    chk("t6_regrant_busy", 32'(bus.busy), 32'd1);
    chk("t6_regrant_data", bus.out_tdata, expd(1, 0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
